// File: rtl/pcint_pkg.sv
// Shared constants and helpers for the pin-change interrupt controller.
package pcint_pkg;

  localparam int         N_GROUPS_MAX   = 4;
  localparam logic [5:0] PCIFR_ADDR_DEF = 6'h1B;
  localparam logic [7:0] PCICR_ADDR_DEF = 8'h68;
  localparam logic [7:0] PCMSK_BASE_DEF = 8'h6B;

  // Zero every PCICR/PCIFR bit that has no group behind it.
  function automatic logic [7:0] mask_groups(input logic [N_GROUPS_MAX-1:0] bits,
                                             input int n_groups);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < N_GROUPS_MAX; i++) begin
      if (i < n_groups) r[i] = bits[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pcint_group.sv
// One pin-change group: mask register, previous-level capture, any-edge detect, sticky flag.
module pcint_group
  import pcint_pkg::*;
(
  input  logic       cp2,
  input  logic       ireset,
  input  logic [7:0] pins,
  input  logic       msk_we,
  input  logic [7:0] msk_wdata,
  input  logic       flag_clr,
  output logic       change,
  output logic       flag,
  output logic [7:0] msk
);

  logic [7:0] prev_q;

  // prev_q reloads even in reset so the first post-reset cycle sees no edge.
  always_ff @(posedge cp2) begin
    prev_q <= pins;
  end

  assign change = |((pins ^ prev_q) & msk);

  // A new edge outranks a clear in the same cycle so no event is lost.
  always_ff @(posedge cp2) begin
    if (ireset) begin
      msk  <= '0;
      flag <= 1'b0;
    end else begin
      if (msk_we) msk <= msk_wdata;
      if (change)        flag <= 1'b1;
      else if (flag_clr) flag <= 1'b0;
    end
  end

endmodule

// File: rtl/pcint_ctrl.sv
// Pin-change interrupt controller: PCICR/PCIFR/PCMSKn registers and per-group irq requests.
// Optional PCINT_WAKE_EN adds a combinational pc_wake output for the sleep controller.
module pcint_ctrl
  import pcint_pkg::*;
#(
  parameter int         N_GROUPS      = 4,
  parameter logic [5:0] PCIFR_Address = PCIFR_ADDR_DEF,
  parameter logic [7:0] PCICR_Address = PCICR_ADDR_DEF,
  parameter logic [7:0] PCMSK_Base    = PCMSK_BASE_DEF
) (
  input  logic                  cp2,
  input  logic                  ireset,
  input  logic [5:0]            IO_Addr,
  input  logic                  iore,
  input  logic                  iowe,
  input  logic [7:0]            ram_Addr,
  input  logic                  ramre,
  input  logic                  ramwe,
  input  logic [7:0]            dbus_in,
  output logic [7:0]            dbus_out,
  output logic                  out_en,
  input  logic [8*N_GROUPS-1:0] pin_in,
  output logic [N_GROUPS-1:0]   irq_req,
`ifdef PCINT_WAKE_EN
  output logic [N_GROUPS-1:0]   pc_wake,
`endif
  input  logic [N_GROUPS-1:0]   irq_ack
);

  logic [N_GROUPS-1:0]     pcie;
  logic [N_GROUPS-1:0]     flag;
  logic [N_GROUPS-1:0]     change;
  logic [N_GROUPS-1:0]     msk_we;
  logic [N_GROUPS-1:0]     flag_clr;
  logic [7:0]              msk [N_GROUPS];
  logic [N_GROUPS_MAX-1:0] flag_ext;
  logic [N_GROUPS_MAX-1:0] pcie_ext;
  logic                    pcifr_wr;
  logic                    pcicr_wr;

  assign pcifr_wr = iowe  && (IO_Addr  == PCIFR_Address);
  assign pcicr_wr = ramwe && (ram_Addr == PCICR_Address);

  always_ff @(posedge cp2) begin
    if (ireset)        pcie <= '0;
    else if (pcicr_wr) pcie <= dbus_in[N_GROUPS-1:0];
  end

  for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
    localparam logic [7:0] MSK_ADDR = PCMSK_Base + 8'(g);

    assign msk_we[g]   = ramwe && (ram_Addr == MSK_ADDR);
    assign flag_clr[g] = (pcifr_wr && dbus_in[g]) || irq_ack[g];

    pcint_group u_grp (
      .cp2       (cp2),
      .ireset    (ireset),
      .pins      (pin_in[8*g +: 8]),
      .msk_we    (msk_we[g]),
      .msk_wdata (dbus_in),
      .flag_clr  (flag_clr[g]),
      .change    (change[g]),
      .flag      (flag[g]),
      .msk       (msk[g])
    );
  end

  assign irq_req = flag & pcie;

`ifdef PCINT_WAKE_EN
  assign pc_wake = change & pcie;
`else
  // change only feeds the flags in this build.
  logic unused_change;
  assign unused_change = ^change;
`endif

  always_comb begin
    flag_ext = '0;
    pcie_ext = '0;
    flag_ext[N_GROUPS-1:0] = flag;
    pcie_ext[N_GROUPS-1:0] = pcie;
  end

  always_comb begin
    dbus_out = '0;
    out_en   = 1'b0;
    if (iore && (IO_Addr == PCIFR_Address)) begin
      out_en   = 1'b1;
      dbus_out = mask_groups(flag_ext, N_GROUPS);
    end else if (ramre && (ram_Addr == PCICR_Address)) begin
      out_en   = 1'b1;
      dbus_out = mask_groups(pcie_ext, N_GROUPS);
    end else begin
      for (int g = 0; g < N_GROUPS; g++) begin
        if (ramre && (ram_Addr == PCMSK_Base + 8'(g))) begin
          out_en   = 1'b1;
          dbus_out = msk[g];
        end
      end
    end
  end

endmodule
